// File: rtl/sw_ctrl_pkg.sv
// Shared types for the Smith-Waterman run sequencer: FSM states, scoring parameters
// and small state-classification helpers.
package sw_ctrl_pkg;

  localparam int unsigned SW_RES_W = 18;

  typedef enum logic [2:0] {
    StIdle,
    StSet,
    StGap,
    StStart,
    StWaitBusy,
    StWaitValid,
    StRecord,
    StDone
  } sw_state_e;

  typedef struct packed {
    logic [3:0] match;
    logic [3:0] mismatch;
    logic [3:0] alpha;
    logic [3:0] beta;
  } sw_params_t;

  // States in which a run is in flight and its compute cycles are accumulated.
  function automatic logic is_run_state(sw_state_e s);
    return (s == StStart) || (s == StWaitBusy) || (s == StWaitValid);
  endfunction

  function automatic logic is_wait_state(sw_state_e s);
    return (s == StWaitBusy) || (s == StWaitValid);
  endfunction

endpackage

// File: rtl/sw_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sw_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RST_N,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/sw_run_sequencer.sv
// Drives the Smith-Waterman wrapper through a batch of runs and collects last/best score,
// accumulated compute cycles and a per-run timeout indication.
module sw_run_sequencer
  import sw_ctrl_pkg::*;
#(
  parameter int unsigned RES_W   = SW_RES_W,
  parameter int unsigned CYC_W   = 32,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned SET_GAP = 4,
  parameter int unsigned TIMEOUT = 50000000
) (
  input  logic             CLOCK,
  input  logic             RST_N,
  input  logic             i_go,
  input  logic             i_abort,
  input  logic [CNT_W-1:0] i_batch_len,
  input  logic [3:0]       i_match,
  input  logic [3:0]       i_mismatch,
  input  logic [3:0]       i_alpha,
  input  logic [3:0]       i_beta,
  output logic             o_set_t,
  output logic             o_start_cal,
  output logic [3:0]       o_match,
  output logic [3:0]       o_mismatch,
  output logic [3:0]       o_alpha,
  output logic [3:0]       o_beta,
  input  logic             i_busy,
  input  logic             i_valid,
  input  logic [RES_W-1:0] i_result,
  output logic [RES_W-1:0] o_last_score,
  output logic [RES_W-1:0] o_best_score,
  output logic [CNT_W-1:0] o_runs_done,
  output logic [CYC_W-1:0] o_cycles,
  output logic             o_active,
  output logic             o_done,
  output logic             o_timeout
);

  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = (SET_GAP > 1) ? $clog2(SET_GAP) : 1;

  sw_state_e        r_state;
  sw_state_e        w_state_next;
  sw_params_t       r_params;
  logic [CNT_W-1:0] r_batch_n;
  logic [CNT_W-1:0] r_runs;
  logic [RES_W-1:0] r_result;
  logic [RES_W-1:0] r_last;
  logic [RES_W-1:0] r_best;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_timeout;

  logic [TO_W-1:0]  w_to_count;
  logic [CNT_W:0]   w_runs_inc;
  logic             w_go_accept;
  logic             w_capture;
  logic             w_to_hit;
  logic             w_to_limit;
  logic             w_in_wait;
  logic             w_cyc_inc;
  logic             w_commit;

  assign w_in_wait  = is_wait_state(r_state);
  assign w_cyc_inc  = is_run_state(r_state);
  assign w_to_limit = (w_to_count >= TO_W'(TIMEOUT - 1));
  assign w_runs_inc = {1'b0, r_runs} + (CNT_W + 1)'(1);
  assign w_commit   = (r_state == StRecord) && !i_abort;

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_go_accept  = 1'b0;
    w_capture    = 1'b0;
    w_to_hit     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_go && !i_abort) begin
          w_go_accept  = 1'b1;
          w_state_next = StSet;
        end
      end
      StSet:   w_state_next = (SET_GAP == 0) ? StStart : StGap;
      StGap: begin
        if (r_gap_cnt == GAP_W'(SET_GAP - 1)) begin
          w_state_next = StStart;
        end
      end
      StStart: w_state_next = StWaitBusy;
      // A fast wrapper may answer before ever raising busy; valid beats the timeout.
      StWaitBusy: begin
        if (i_valid) begin
          w_capture    = 1'b1;
          w_state_next = StRecord;
        end else if (w_to_limit) begin
          w_to_hit     = 1'b1;
          w_state_next = StIdle;
        end else if (i_busy) begin
          w_state_next = StWaitValid;
        end
      end
      StWaitValid: begin
        if (i_valid) begin
          w_capture    = 1'b1;
          w_state_next = StRecord;
        end else if (w_to_limit) begin
          w_to_hit     = 1'b1;
          w_state_next = StIdle;
        end
      end
      StRecord: w_state_next = (w_runs_inc < {1'b0, r_batch_n}) ? StStart : StDone;
      StDone:   w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
    if (i_abort && (r_state != StIdle)) begin
      w_state_next = StIdle;
      w_capture    = 1'b0;
      w_to_hit     = 1'b0;
    end
  end

  always_ff @(posedge CLOCK or negedge RST_N) begin
    if (!RST_N) begin
      r_params  <= '0;
      r_batch_n <= '0;
      r_runs    <= '0;
      r_result  <= '0;
      r_last    <= '0;
      r_best    <= '0;
      r_gap_cnt <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_go_accept) begin
        r_params.match    <= i_match;
        r_params.mismatch <= i_mismatch;
        r_params.alpha    <= i_alpha;
        r_params.beta     <= i_beta;
        r_batch_n         <= (i_batch_len == '0) ? CNT_W'(1) : i_batch_len;
        r_runs            <= '0;
        r_last            <= '0;
        r_best            <= '0;
        r_timeout         <= 1'b0;
      end
      if (w_capture) begin
        r_result <= i_result;
      end
      if (w_commit) begin
        r_last <= r_result;
        r_runs <= w_runs_inc[CNT_W-1:0];
        if (r_result > r_best) begin
          r_best <= r_result;
        end
      end
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
      r_gap_cnt <= (r_state == StGap) ? r_gap_cnt + GAP_W'(1) : '0;
    end
  end

  sw_sat_counter #(
    .WIDTH(CYC_W)
  ) u_cycle_acc (
    .CLOCK  (CLOCK),
    .RST_N  (RST_N),
    .i_clear(w_go_accept),
    .i_inc  (w_cyc_inc),
    .o_count(o_cycles)
  );

  // Restarts at zero on entry to every run's wait phase.
  sw_sat_counter #(
    .WIDTH(TO_W)
  ) u_timeout_cnt (
    .CLOCK  (CLOCK),
    .RST_N  (RST_N),
    .i_clear(!w_in_wait),
    .i_inc  (w_in_wait),
    .o_count(w_to_count)
  );

  assign o_set_t      = (r_state == StSet);
  assign o_start_cal  = (r_state == StStart);
  assign o_done       = (r_state == StDone);
  assign o_active     = (r_state != StIdle) && (r_state != StDone);
  assign o_match      = r_params.match;
  assign o_mismatch   = r_params.mismatch;
  assign o_alpha      = r_params.alpha;
  assign o_beta       = r_params.beta;
  assign o_last_score = r_last;
  assign o_best_score = r_best;
  assign o_runs_done  = r_runs;
  assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_sw_run_sequencer.sv
// Self-checking bench: behavioural wrapper, cycle-timeline reference model and directed batches.
module tb_sw_run_sequencer;

  localparam int unsigned RES_W   = 18;
  localparam int unsigned CYC_W   = 32;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned SET_GAP = 4;
  localparam int unsigned TIMEOUT = 100;

  logic             CLOCK = 1'b0;
  logic             RST_N = 1'b0;
  logic             i_go = 1'b0, i_abort = 1'b0;
  logic [CNT_W-1:0] i_batch_len = '0;
  logic [3:0]       i_match = '0, i_mismatch = '0, i_alpha = '0, i_beta = '0;
  logic             i_busy = 1'b0, i_valid = 1'b0;
  logic [RES_W-1:0] i_result = '0;
  logic             o_set_t, o_start_cal, o_active, o_done, o_timeout;
  logic [3:0]       o_match, o_mismatch, o_alpha, o_beta;
  logic [RES_W-1:0] o_last_score, o_best_score;
  logic [CNT_W-1:0] o_runs_done;
  logic [CYC_W-1:0] o_cycles;

  sw_run_sequencer #(
    .RES_W(RES_W), .CYC_W(CYC_W), .CNT_W(CNT_W), .SET_GAP(SET_GAP), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLOCK(CLOCK), .RST_N(RST_N), .i_go(i_go), .i_abort(i_abort), .i_batch_len(i_batch_len),
    .i_match(i_match), .i_mismatch(i_mismatch), .i_alpha(i_alpha), .i_beta(i_beta),
    .o_set_t(o_set_t), .o_start_cal(o_start_cal), .o_match(o_match),
    .o_mismatch(o_mismatch), .o_alpha(o_alpha), .o_beta(o_beta), .i_busy(i_busy),
    .i_valid(i_valid), .i_result(i_result), .o_last_score(o_last_score),
    .o_best_score(o_best_score), .o_runs_done(o_runs_done), .o_cycles(o_cycles),
    .o_active(o_active), .o_done(o_done), .o_timeout(o_timeout)
  );

  always #5 CLOCK = ~CLOCK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural wrapper: busy from 2 cycles after start_cal, one-cycle valid after wr_lat.
  int               wr_k = -1;
  int               wr_lat = 10;
  bit               wr_never = 1'b0;
  int               wr_idx = 0;
  logic [RES_W-1:0] wr_res [0:7];
  logic             wr_st;

  initial forever begin
    @(posedge CLOCK);
    wr_st = o_start_cal;
    #1;
    if (!RST_N) wr_k = -1;
    else if (wr_st) wr_k = 1;
    else if (wr_k >= 1) wr_k++;
    i_busy  = RST_N && (wr_k >= 2) && (wr_never || (wr_k < wr_lat));
    i_valid = RST_N && !wr_never && (wr_k == wr_lat);
    if (i_valid) begin
      i_result = wr_res[wr_idx];
      wr_idx++;
      wr_k = -1;
    end else begin
      i_result = '1;  // junk outside valid
    end
  end

  // Reference model: schedule of expected events indexed by cycle number.
  longint           m_c = 0, m_set_c = -1, m_start_c = -1, m_done_c = -1, m_rec_c = -1;
  longint           m_cyc_base = 0;
  bit               m_act = 0, m_run = 0, m_to = 0;
  int unsigned      m_n = 0, m_runs = 0;
  logic [RES_W-1:0] m_last = '0, m_best = '0, m_pend = '0;
  logic [3:0]       m_par [0:3] = '{4'd0, 4'd0, 4'd0, 4'd0};

  initial forever begin
    @(posedge CLOCK or negedge RST_N);
    if (!RST_N) begin
      m_set_c = -1; m_start_c = -1; m_done_c = -1; m_rec_c = -1; m_cyc_base = 0;
      m_act = 0; m_run = 0; m_to = 0; m_n = 0; m_runs = 0;
      m_last = '0; m_best = '0; m_pend = '0;
      for (int i = 0; i < 4; i++) m_par[i] = 4'd0;
    end else begin
      if (!m_act && (m_c != m_done_c)) begin
        if (i_go && !i_abort) begin
          m_act = 1; m_run = 0; m_rec_c = -1;
          m_set_c = m_c + 1;
          m_start_c = m_c + 2 + SET_GAP;
          m_n = (i_batch_len == 0) ? 1 : i_batch_len;
          m_runs = 0; m_last = '0; m_best = '0; m_cyc_base = 0; m_to = 0;
          m_par[0] = i_match; m_par[1] = i_mismatch; m_par[2] = i_alpha; m_par[3] = i_beta;
        end
      end else if (m_act && i_abort) begin
        if (m_run || (m_c == m_start_c)) m_cyc_base += m_c - m_start_c + 1;
        m_act = 0; m_run = 0; m_start_c = -1; m_rec_c = -1;
      end else if (m_act) begin
        if (m_c == m_start_c) begin
          m_run = 1;
        end else if (m_run) begin
          if (i_valid) begin
            m_pend = i_result;
            m_cyc_base += m_c - m_start_c + 1;
            m_run = 0;
            m_rec_c = m_c + 1;
          end else if (m_c - m_start_c == TIMEOUT) begin
            m_cyc_base += m_c - m_start_c + 1;
            m_run = 0; m_act = 0; m_to = 1;
          end
        end else if (m_c == m_rec_c) begin
          m_last = m_pend;
          if (m_pend > m_best) m_best = m_pend;
          m_runs++;
          if (m_runs < m_n) m_start_c = m_c + 1;
          else begin
            m_done_c = m_c + 1;
            m_act = 0;
          end
        end
      end
      m_c++;
    end
  end

  // Per-cycle comparison against the model, plus pulse bookkeeping for literal checks.
  longint cyc = 0, set_at = -1, start_at = -1;
  int     set_cnt = 0, start_cnt = 0, done_cnt = 0;

  initial forever begin
    @(negedge CLOCK);
    cyc++;
    if (RST_N) begin
      chk("set_t", o_set_t, (m_c == m_set_c));
      chk("start_cal", o_start_cal, (m_c == m_start_c));
      chk("done", o_done, (m_c == m_done_c));
      chk("active", o_active, m_act);
      chk("timeout", o_timeout, m_to);
      chk("last_score", o_last_score, m_last);
      chk("best_score", o_best_score, m_best);
      chk("runs_done", o_runs_done, m_runs);
      chk("cycles", o_cycles, m_cyc_base + (m_run ? m_c - m_start_c : 0));
      chk("params", {o_match, o_mismatch, o_alpha, o_beta},
          {m_par[0], m_par[1], m_par[2], m_par[3]});
      if (o_set_t) begin set_cnt++; set_at = cyc; end
      if (o_start_cal) begin start_cnt++; if (start_at < 0) start_at = cyc; end
      if (o_done) done_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic clear_counts();
    set_cnt = 0; start_cnt = 0; done_cnt = 0; set_at = -1; start_at = -1; wr_idx = 0;
  endtask

  task automatic go(input int len);
    i_batch_len = CNT_W'(len);
    i_go = 1'b1;
    tick(1);
    i_go = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    tick(1);
    while (o_active && n < 3000) begin
      tick(1);
      n++;
    end
    if (o_active) chk({name, "_idle_bound"}, 1, 0);
    tick(2);
  endtask

  int n_st;

  initial begin
    for (int i = 0; i < 8; i++) wr_res[i] = '0;
    i_match = 4'd3; i_mismatch = 4'd2; i_alpha = 4'd4; i_beta = 4'd1;
    tick(3);
    chk("rst_active", o_active, 0);
    chk("rst_cycles", o_cycles, 0);
    chk("rst_last", o_last_score, 0);
    chk("rst_match", o_match, 0);
    chk("rst_set_t", o_set_t, 0);
    RST_N = 1'b1;
    tick(2);

    // Single run, L=10, result 37.
    clear_counts(); wr_lat = 10; wr_res[0] = 18'd37;
    go(1);
    wait_idle("t1");
    chk("t1_last", o_last_score, 37);
    chk("t1_best", o_best_score, 37);
    chk("t1_cycles", o_cycles, 11);
    chk("t1_runs", o_runs_done, 1);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_set_cnt", set_cnt, 1);
    chk("t1_set_to_start", start_at - set_at, 5);
    chk("t1_match", o_match, 3);

    // Three runs.
    clear_counts(); wr_res[0] = 18'd12; wr_res[1] = 18'd40; wr_res[2] = 18'd25;
    go(3);
    wait_idle("t2");
    chk("t2_best", o_best_score, 40);
    chk("t2_last", o_last_score, 25);
    chk("t2_runs", o_runs_done, 3);
    chk("t2_set_cnt", set_cnt, 1);
    chk("t2_start_cnt", start_cnt, 3);
    chk("t2_cycles", o_cycles, 33);

    // Zero length is one run.
    clear_counts(); wr_res[0] = 18'd99;
    go(0);
    wait_idle("t3");
    chk("t3_runs", o_runs_done, 1);
    chk("t3_start_cnt", start_cnt, 1);
    chk("t3_done_cnt", done_cnt, 1);

    // Wrapper never answers.
    clear_counts(); wr_never = 1'b1;
    go(2);
    wait_idle("t4");
    wr_never = 1'b0;
    chk("t4_timeout", o_timeout, 1);
    chk("t4_done_cnt", done_cnt, 0);
    chk("t4_active", o_active, 0);
    chk("t4_cycles", o_cycles, 101);
    chk("t4_start_cnt", start_cnt, 1);

    // Abort on the same cycle as the second run's valid.
    clear_counts(); wr_res[0] = 18'd50; wr_res[1] = 18'd60;
    go(2);
    n_st = 0;
    for (int i = 0; i < 200 && n_st < 2; i++) begin
      tick(1);
      if (o_start_cal) n_st++;
    end
    chk("t5_second_start", n_st, 2);
    tick(wr_lat);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    tick(3);
    chk("t5_runs", o_runs_done, 1);
    chk("t5_last", o_last_score, 50);
    chk("t5_done_cnt", done_cnt, 0);
    chk("t5_active", o_active, 0);
    chk("t5_timeout", o_timeout, 0);
    chk("t5_cycles", o_cycles, 22);

    // Go while busy is ignored; parameter changes mid-batch have no effect.
    clear_counts(); wr_res[0] = 18'd7;
    go(1);
    tick(3);
    i_match = 4'd9;
    go(5);
    wait_idle("t6");
    chk("t6_runs", o_runs_done, 1);
    chk("t6_set_cnt", set_cnt, 1);
    chk("t6_start_cnt", start_cnt, 1);
    chk("t6_match", o_match, 3);
    chk("t6_last", o_last_score, 7);

    // Abort and go together in idle: go ignored.
    clear_counts();
    i_abort = 1'b1;
    go(1);
    i_abort = 1'b0;
    tick(3);
    chk("t6b_set_cnt", set_cnt, 0);
    chk("t6b_active", o_active, 0);

    // Asynchronous reset in the middle of a batch.
    clear_counts(); i_match = 4'd6; wr_res[0] = 18'd5; wr_res[1] = 18'd9;
    go(2);
    for (int i = 0; i < 200 && o_runs_done != 1; i++) tick(1);
    chk("t7_first_run", o_runs_done, 1);
    @(posedge CLOCK);
    #3;
    RST_N = 1'b0;
    #1;
    chk("t7_runs", o_runs_done, 0);
    chk("t7_last", o_last_score, 0);
    chk("t7_cycles", o_cycles, 0);
    chk("t7_active", o_active, 0);
    chk("t7_match", o_match, 0);
    tick(2);
    RST_N = 1'b1;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
